clint_vec: RTL
==============

// Module: clint_vec
// PURPOSE
//  Parametrised successor to the single-source core-local interrupt controller.
//  Accepts NUM_IRQ external sources with per-source pending latch, enable mask and
//  edge/level mode, and picks a winner by fixed priority (index 0 highest).
//  Handles ECALL/EBREAK/MRET from the WB stage and supports direct and vectored
//  mtvec modes. Writes mepc/mcause/mstatus through the csr_reg write port, holds
//  the pipeline via flow_ctrl, then issues the redirect.
// PARAMETERS
//  NUM_IRQ         8       number of external interrupt sources (1..32)
//  IRQ_EDGE        'h0     bit i=1: source i is rising-edge latched; 0: level
//  CAUSE_BASE      16      mcause code of source 0; source i uses CAUSE_BASE+i
//  CPU_WIDTH       32      data/address width
//  CSR_ADDR_WIDTH  12      CSR address width
// PORTS
//  clk             in   1               core clock
//  rst             in   1               synchronous, active-high reset
//  irq_i           in   NUM_IRQ         raw interrupt lines
//  irq_en_i        in   NUM_IRQ         per-source enable (mie image)
//  pc_inst_addr_i  in   CPU_WIDTH       IF-stage PC (async resume address)
//  wb_inst_i       in   CPU_WIDTH       instruction word in WB
//  wb_inst_addr_i  in   CPU_WIDTH       address of the WB instruction
//  csr_mtvec       in   CPU_WIDTH       mtvec; [1:0]=01 selects vectored mode
//  csr_mepc        in   CPU_WIDTH       mepc
//  csr_mstatus     in   CPU_WIDTH       mstatus; bit3 MIE, bit7 MPIE
//  we_o            out  1               CSR write enable
//  waddr_o         out  CSR_ADDR_WIDTH  CSR write address
//  data_o          out  CPU_WIDTH       CSR write data
//  hold_flag_o     out  1               pipeline stall request
//  int_addr_o      out  CPU_WIDTH       redirect target
//  int_assert_o    out  1               redirect strobe, one-cycle pulse
//  irq_claim_o     out  NUM_IRQ         one-hot claim pulse to the source
// BEHAVIOUR
//  - Reset: state=IDLE, pending=0, edge history=0. All outputs 0.
//    rst in any state aborts the sequence on that edge; no partial redirect.
//  - Pending: edge source sets pend[i] on irq_i 0->1; level source has pend[i]=irq_i.
//    An edge pend[i] clears only on its claim. A set and a claim in the same
//    cycle leaves it set.
//  - Request priority, evaluated only in IDLE: ECALL/EBREAK in WB >
//    async (|(pend & irq_en_i) && MIE) > MRET in WB.
//  - Winner id is the lowest set index of pend & irq_en_i.
//  - Trap FSM: IDLE->MEPC->MCAUSE->MSTATUS->JUMP->IDLE, one cycle per state.
//    MRET path: IDLE->MRET->IDLE.
//  - On leaving IDLE, latch epc, cause and id:
//      sync: epc=wb_inst_addr_i; cause=11 (ECALL) or 3 (EBREAK).
//      async: epc=pc_inst_addr_i; cause={1'b1, CAUSE_BASE+id}.
//  - we_o/waddr_o/data_o decode combinationally from the registered state:
//      MEPC    -> CSR_MEPC, epc
//      MCAUSE  -> CSR_MCAUSE, cause
//      MSTATUS -> CSR_MSTATUS, MPIE<=MIE, MIE<=0
//      MRET    -> CSR_MSTATUS, MIE<=MPIE, MPIE<=1
//      other states -> we_o=0, addr=0, data=0.
//  - irq_claim_o[id] is high for exactly the MEPC cycle of an async trap.
//    It is 0 otherwise.
//  - int_assert_o is registered: high the cycle after JUMP or MRET, for one cycle.
//      trap: int_addr_o = base, or base+4*cause[30:0] for async when vectored.
//            base = {mtvec[31:2],2'b00}.
//      mret: int_addr_o = csr_mepc.
//    int_addr_o is 0 when int_assert_o is 0.
//  - hold_flag_o = (state!=IDLE) | trap/MRET request in IDLE | int_assert_o.
//  - Latency: request seen at cycle 0 gives int_assert_o at cycle 5 for a trap,
//    cycle 2 for MRET. New requests are ignored until back in IDLE.
// TESTING
//  - ECALL at 0x100, mtvec=0x200: mepc=0x100, mcause=11, MIE 1->0, MPIE=1;
//    int_addr_o=0x200 at cycle 5.
//  - irq_i[5] and irq_i[2] pulse together, both enabled, vectored mtvec=0x401:
//    id 2 claimed; mcause=0x80000012; int_addr_o=0x448; pend[5] stays set.
//  - Source 3 enabled but MIE=0: no trap. Set MIE=1 -> trap taken;
//    a disabled source never claims.
//  - MRET with mepc=0x84, MPIE=1: mstatus MIE=1, MPIE=1;
//    int_addr_o=0x84 two cycles later.
//  - ECALL and async IRQ in the same cycle: sync wins; IRQ stays pending and is
//    taken once MIE is restored.
//  - rst asserted in MCAUSE state: next cycle IDLE, all outputs 0, pending
//    cleared, no int_assert_o pulse.

Source files
------------

// File: rtl/clint_vec.sv
// Core-local interrupt controller: NUM_IRQ prioritised external sources, ECALL/EBREAK/MRET
// handling, CSR write sequencing, pipeline hold and redirect for direct/vectored mtvec.
module clint_vec #(
   parameter int unsigned NUM_IRQ        = 8,
   parameter logic [31:0] IRQ_EDGE       = 32'h0,
   parameter int unsigned CAUSE_BASE     = 16,
   parameter int unsigned CPU_WIDTH      = 32,
   parameter int unsigned CSR_ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_IRQ-1:0]        irq_i,
   input  logic [NUM_IRQ-1:0]        irq_en_i,
   input  logic [CPU_WIDTH-1:0]      pc_inst_addr_i,
   input  logic [CPU_WIDTH-1:0]      wb_inst_i,
   input  logic [CPU_WIDTH-1:0]      wb_inst_addr_i,
   input  logic [CPU_WIDTH-1:0]      csr_mtvec,
   input  logic [CPU_WIDTH-1:0]      csr_mepc,
   input  logic [CPU_WIDTH-1:0]      csr_mstatus,
   output logic                      we_o,
   output logic [CSR_ADDR_WIDTH-1:0] waddr_o,
   output logic [CPU_WIDTH-1:0]      data_o,
   output logic                      hold_flag_o,
   output logic [CPU_WIDTH-1:0]      int_addr_o,
   output logic                      int_assert_o,
   output logic [NUM_IRQ-1:0]        irq_claim_o
);

   localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

   localparam logic [CPU_WIDTH-1:0] INST_ECALL  = CPU_WIDTH'(32'h0000_0073);
   localparam logic [CPU_WIDTH-1:0] INST_EBREAK = CPU_WIDTH'(32'h0010_0073);
   localparam logic [CPU_WIDTH-1:0] INST_MRET   = CPU_WIDTH'(32'h3020_0073);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MEPC,
      ST_MCAUSE,
      ST_MSTATUS,
      ST_JUMP,
      ST_MRET
   } state_e;

   state_e                state_q, state_d;
   logic [NUM_IRQ-1:0]    pend_q, pend_d;
   logic [NUM_IRQ-1:0]    irq_prev_q, irq_prev_d;
   logic [NUM_IRQ-1:0]    pend, req_vec, claim;
   logic [ID_W-1:0]       id_q, id_d, win_id;
   logic                  win_found;
   logic                  async_q, async_d;
   logic [CPU_WIDTH-1:0]  epc_q, epc_d;
   logic [CPU_WIDTH-1:0]  cause_q, cause_d;
   logic [CPU_WIDTH-1:0]  int_addr_q, int_addr_d;
   logic [CPU_WIDTH-1:0]  trap_base;
   logic                  int_assert_q, int_assert_d;
   logic                  is_ebreak, sync_req, async_req, mret_req;

   // Edge sources keep a sticky latch cleared by their own claim; a new edge
   // arriving in the claim cycle wins. Level sources follow the raw line.
   always_comb begin
      pend       = '0;
      pend_d     = '0;
      irq_prev_d = irq_i;
      win_id     = '0;
      win_found  = 1'b0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (IRQ_EDGE[i]) begin
            pend[i]   = pend_q[i];
            pend_d[i] = (pend_q[i] & ~claim[i]) | (irq_i[i] & ~irq_prev_q[i]);
         end else begin
            pend[i] = irq_i[i];
         end
      end
      req_vec = pend & irq_en_i;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (!win_found && req_vec[i]) begin
            win_id    = ID_W'(i);
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      is_ebreak = (wb_inst_i == INST_EBREAK);
      sync_req  = (wb_inst_i == INST_ECALL) | is_ebreak;
      async_req = (|req_vec) & csr_mstatus[3];
      mret_req  = (wb_inst_i == INST_MRET);
   end

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      id_d    = id_q;
      async_d = async_q;
      case (state_q)
         ST_IDLE: begin
            if (sync_req) begin
               state_d = ST_MEPC;
               epc_d   = wb_inst_addr_i;
               cause_d = is_ebreak ? CPU_WIDTH'(3) : CPU_WIDTH'(11);
               async_d = 1'b0;
            end else if (async_req) begin
               state_d                  = ST_MEPC;
               epc_d                    = pc_inst_addr_i;
               cause_d                  = '0;
               cause_d[CPU_WIDTH-1]     = 1'b1;
               cause_d[CPU_WIDTH-2:0]   = (CPU_WIDTH-1)'(CAUSE_BASE) + (CPU_WIDTH-1)'(win_id);
               id_d                     = win_id;
               async_d                  = 1'b1;
            end else if (mret_req) begin
               state_d = ST_MRET;
            end
         end
         ST_MEPC:    state_d = ST_MCAUSE;
         ST_MCAUSE:  state_d = ST_MSTATUS;
         ST_MSTATUS: state_d = ST_JUMP;
         ST_JUMP:    state_d = ST_IDLE;
         ST_MRET:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      we_o         = 1'b0;
      waddr_o      = '0;
      data_o       = '0;
      claim        = '0;
      int_assert_d = 1'b0;
      int_addr_d   = '0;
      trap_base    = {csr_mtvec[CPU_WIDTH-1:2], 2'b00};
      case (state_q)
         ST_MEPC: begin
            we_o    = 1'b1;
            waddr_o = CSR_MEPC;
            data_o  = epc_q;
            if (async_q) begin
               for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                  claim[i] = (id_q == ID_W'(i));
               end
            end
         end
         ST_MCAUSE: begin
            we_o    = 1'b1;
            waddr_o = CSR_MCAUSE;
            data_o  = cause_q;
         end
         ST_MSTATUS: begin
            we_o      = 1'b1;
            waddr_o   = CSR_MSTATUS;
            data_o    = csr_mstatus;
            data_o[7] = csr_mstatus[3];
            data_o[3] = 1'b0;
         end
         ST_JUMP: begin
            int_assert_d = 1'b1;
            if (async_q && (csr_mtvec[1:0] == 2'b01)) begin
               int_addr_d = trap_base + {cause_q[CPU_WIDTH-3:0], 2'b00};
            end else begin
               int_addr_d = trap_base;
            end
         end
         ST_MRET: begin
            we_o         = 1'b1;
            waddr_o      = CSR_MSTATUS;
            data_o       = csr_mstatus;
            data_o[3]    = csr_mstatus[7];
            data_o[7]    = 1'b1;
            int_assert_d = 1'b1;
            int_addr_d   = csr_mepc;
         end
         default: ;
      endcase
   end

   always_comb begin
      irq_claim_o  = claim;
      int_assert_o = int_assert_q;
      int_addr_o   = int_addr_q;
      hold_flag_o  = (state_q != ST_IDLE)
                   | ((state_q == ST_IDLE) & (sync_req | async_req | mret_req))
                   | int_assert_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pend_q       <= '0;
         irq_prev_q   <= '0;
         id_q         <= '0;
         async_q      <= 1'b0;
         epc_q        <= '0;
         cause_q      <= '0;
         int_assert_q <= 1'b0;
         int_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         irq_prev_q   <= irq_prev_d;
         id_q         <= id_d;
         async_q      <= async_d;
         epc_q        <= epc_d;
         cause_q      <= cause_d;
         int_assert_q <= int_assert_d;
         int_addr_q   <= int_addr_d;
      end
   end

endmodule
